absorb_scheduler: RTL and testbench
===================================

ABSORB_SCHEDULER -- requirements
Module: absorb_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: entries in the input word buffer; minimum 4.
REQ-002 Parameter BLKCNT_W, default 16: width of the absorbed-block counter.
REQ-003 Clock and reset: one clock, clk; reset rstn, asynchronous, active-low.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rstn  in  1  asynchronous active-low reset.
REQ-006 mode  in  1  0 = SHAKE128 (rate 21 lanes), 1 = SHAKE256 (rate 17 lanes); sampled on the first accepted word of a message.
REQ-007 msgn  in  64  padded message word from the message processor; first byte is in [63:56].
REQ-008 msgn_val  in  1  msgn is valid this cycle.
REQ-009 lastmsgn_val  in  1  final word of the message; 0x1F domain byte already included.
REQ-010 in_ready  out  1  upstream may present a new raw message word to the message processor.
REQ-011 lane_data  out  64  lane value to be XORed into the Keccak state.
REQ-012 lane_idx  out  5  target lane, 0..RATE-1.
REQ-013 lane_we  out  1  lane_data/lane_idx are valid for one XOR write.
REQ-014 perm_start  out  1  one-cycle pulse that starts the Keccak-f[1600] permutation.
REQ-015 perm_done  in  1  one-cycle pulse marking permutation complete.
REQ-016 absorb_done  out  1  one-cycle pulse marking that the whole message is absorbed.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 blk_cnt  out  BLKCNT_W  permutations issued for the current message.
REQ-019 ovf_err  out  1  sticky flag: a word arrived while the FIFO was full.

Function
REQ-020 Incoming {lastmsgn_val, msgn} pairs are pushed into a FIFO_DEPTH x 65 FIFO whenever msgn_val=1; a push and a pop in the same cycle are both honoured.
REQ-021 in_ready = (fifo_count <= FIFO_DEPTH-3) AND NOT last_seen; last_seen is set when a last word is pushed and cleared in DONE; this leaves room for one accepted word in flight, the processor register, and the processor's trailing word.
REQ-022 A push while the FIFO is full is dropped and sets ovf_err; ovf_err clears only on reset.
REQ-023 State machine: IDLE, ABSORB, PAD, PERM, DONE.
REQ-024 IDLE -> ABSORB when the FIFO is non-empty; rate is latched from mode at this point; lane counter and blk_cnt are set to 0.
REQ-025 ABSORB: each cycle with the FIFO non-empty, pop one word, assert lane_we with lane_idx = lane counter and lane_data = word, then increment the lane counter.
REQ-026 Latency: the word at the FIFO head appears on lane_data in the cycle after it becomes head (registered outputs).
REQ-027 If a popped word is last and lane counter = RATE-1: lane_data = word XOR 64'h80, next state PERM.
REQ-028 If a popped word is last and lane counter < RATE-1: next state PAD.
REQ-029 If a popped word is not last and lane counter = RATE-1: next state PERM, lane counter wraps to 0.
REQ-030 PAD: a single lane_we with lane_idx = RATE-1 and lane_data = 64'h0000_0000_0000_0080, then PERM; zero lanes are not written.
REQ-031 PERM: perm_start is pulsed in the first cycle only; blk_cnt increments on that pulse; the block waits for perm_done.
REQ-032 On perm_done: go to DONE if the final block was absorbed, otherwise go to ABSORB.
REQ-033 perm_done received outside PERM is ignored.
REQ-034 DONE: pulse absorb_done for one cycle, clear last_seen, then go to IDLE; blk_cnt holds until the next message starts.
REQ-035 lane_we, perm_start and absorb_done are never high in the same cycle.

Reset
REQ-036 While rstn=0, asynchronously: state = IDLE, FIFO empty, lane counter 0, blk_cnt 0, last_seen 0.
REQ-037 While rstn=0, all outputs are 0 except in_ready, which is 1.
REQ-038 A reset in any state abandons the message; no further perm_start is issued.

Structure
REQ-039 Shared package keccak_pkg holds RATE128 = 21, RATE256 = 17, PAD_END = 8'h80, DOMAIN = 8'h1F, LANE_W = 64, and the state enum.
REQ-040 The FIFO is a sub-module named msg_fifo (synchronous, parameterised depth/width, with count, full and empty).

Verification
REQ-041 mode=0; 21 words, last on word 21 (word21[7:0]=8'h1F) -> lanes 0..20 written, lane 20 data[7:0] = 8'h9F, one perm_start, blk_cnt=1, absorb_done.
REQ-042 mode=1; 3 words, last on word 3 -> lanes 0,1,2 written, then lane 16 = 64'h80, one perm_start, absorb_done after perm_done.
REQ-043 mode=1; 18 words -> first block lanes 0..16 and perm; second block lane 0 and lane 16 = 64'h80 and perm; blk_cnt=2.
REQ-044 mode=0; continuous 50-word stream with perm_done delayed 30 cycles -> in_ready drops, ovf_err stays 0, all 50 words written in order, blk_cnt=3.
REQ-045 rstn pulsed low during PERM -> outputs match REQ-036/037 immediately; a later perm_done pulse produces no activity.
REQ-046 Force 5 consecutive pushes with no pops (FIFO_DEPTH=4) -> 5th word dropped, ovf_err=1 and stays 1 until reset.

Source files
------------

// File: rtl/keccak_pkg.sv
// -----------------------------------------------------------------------------
// keccak_pkg
// Constants and types shared by the SHAKE absorb path:
//   LANE_W    width of one Keccak lane
//   RATE128   rate of SHAKE128, in lanes
//   RATE256   rate of SHAKE256, in lanes
//   PAD_END   final pad10*1 byte, XORed into the last rate lane
//   DOMAIN    SHAKE domain-separation byte (added by the message processor)
//   state_e   absorb scheduler states
// -----------------------------------------------------------------------------
package keccak_pkg;

  localparam int         LANE_W  = 64;
  localparam int         RATE128 = 21;
  localparam int         RATE256 = 17;
  localparam logic [7:0] PAD_END = 8'h80;
  localparam logic [7:0] DOMAIN  = 8'h1F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABSORB,
    S_PAD,
    S_PERM,
    S_DONE
  } state_e;

  // Rate in lanes for the selected SHAKE variant (0 = SHAKE128, 1 = SHAKE256).
  function automatic logic [4:0] rate_of(input logic mode);
    return mode ? 5'(RATE256) : 5'(RATE128);
  endfunction

endpackage

// File: rtl/absorb_scheduler_if.sv
// -----------------------------------------------------------------------------
// absorb_scheduler_if
// Bundles the message-in side and the lane/permutation-out side of the absorb
// scheduler.
//   slave  : the scheduler (consumes msgn*, mode, perm_done)
//   master : its environment (message processor + Keccak core)
// Signals:
//   mode, msgn, msgn_val, lastmsgn_val   message word stream
//   in_ready                             upstream flow control
//   lane_data, lane_idx, lane_we         one XOR write into the state
//   perm_start, perm_done                permutation handshake
//   absorb_done, busy, blk_cnt, ovf_err  status
// -----------------------------------------------------------------------------
interface absorb_scheduler_if #(
  parameter int BLKCNT_W = 16
);

  logic                          mode;
  logic [keccak_pkg::LANE_W-1:0] msgn;
  logic                          msgn_val;
  logic                          lastmsgn_val;
  logic                          in_ready;
  logic [keccak_pkg::LANE_W-1:0] lane_data;
  logic [4:0]                    lane_idx;
  logic                          lane_we;
  logic                          perm_start;
  logic                          perm_done;
  logic                          absorb_done;
  logic                          busy;
  logic [BLKCNT_W-1:0]           blk_cnt;
  logic                          ovf_err;

  modport slave (
    input  mode, msgn, msgn_val, lastmsgn_val, perm_done,
    output in_ready, lane_data, lane_idx, lane_we, perm_start,
           absorb_done, busy, blk_cnt, ovf_err
  );

  modport master (
    output mode, msgn, msgn_val, lastmsgn_val, perm_done,
    input  in_ready, lane_data, lane_idx, lane_we, perm_start,
           absorb_done, busy, blk_cnt, ovf_err
  );

endinterface

// File: rtl/msg_fifo.sv
// -----------------------------------------------------------------------------
// msg_fifo
// Synchronous FIFO, DEPTH x WIDTH, with show-ahead read (pop_data is the
// current head). A push while full is dropped; push and pop in one cycle are
// both honoured.
// Ports:
//   clk, rstn            clock, async active-low reset
//   push, push_data      write request and data
//   pop, pop_data        read request and head data
//   count, full, empty   occupancy
// -----------------------------------------------------------------------------
module msg_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // NOTE: combinational blocks assign every output a default first so no
  // path through them can infer a latch.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? bump(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? bump(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // NOTE: flops use non-blocking assignment so every register samples the
  // pre-edge value of every other register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; the pointers and count
  // define which entries are meaningful, and this keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/absorb_scheduler.sv
// -----------------------------------------------------------------------------
// absorb_scheduler
// Buffers padded 64-bit message words and schedules their XOR into the rate
// lanes of the Keccak state, inserting the final 0x80 pad byte and issuing one
// permutation per rate block.
// Ports:
//   clk, rstn   clock, async active-low reset
//   bus         absorb_scheduler_if.slave (message in, lane writes out,
//               permutation handshake, status)
// -----------------------------------------------------------------------------
module absorb_scheduler
  import keccak_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int BLKCNT_W   = 16
) (
  input  logic                clk,
  input  logic                rstn,
  absorb_scheduler_if.slave   bus
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [LANE_W:0]     head;
  logic [CW-1:0]       fifo_count;
  logic                fifo_full, fifo_empty, pop;

  state_e              state_q, state_d;
  logic [4:0]          rate_q, rate_d;
  logic [4:0]          lane_q, lane_d;
  logic [BLKCNT_W-1:0] blk_cnt_q, blk_cnt_d;
  logic                last_seen_q, last_seen_d;
  logic                final_q, final_d;        // last word of message popped
  logic                perm_sent_q, perm_sent_d;
  logic                ovf_err_q, ovf_err_d;
  logic                lane_we_q, lane_we_d;
  logic [4:0]          lane_idx_q, lane_idx_d;
  logic [LANE_W-1:0]   lane_data_q, lane_data_d;
  logic                perm_start_q, perm_start_d;
  logic                absorb_done_q, absorb_done_d;

  msg_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(LANE_W + 1), .CNT_W(CW)) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (bus.msgn_val),
    .push_data ({bus.lastmsgn_val, bus.msgn}),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Headroom of three entries: a word in flight, the processor register and
  // the processor's trailing word.
  assign bus.in_ready    = (fifo_count <= CW'(FIFO_DEPTH - 3)) && !last_seen_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.lane_we     = lane_we_q;
  assign bus.lane_idx    = lane_idx_q;
  assign bus.lane_data   = lane_data_q;
  assign bus.perm_start  = perm_start_q;
  assign bus.absorb_done = absorb_done_q;
  assign bus.blk_cnt     = blk_cnt_q;
  assign bus.ovf_err     = ovf_err_q;

  always_comb begin
    state_d       = state_q;
    rate_d        = rate_q;
    lane_d        = lane_q;
    blk_cnt_d     = blk_cnt_q;
    final_d       = final_q;
    perm_sent_d   = perm_sent_q;
    lane_we_d     = 1'b0;
    lane_idx_d    = lane_idx_q;
    lane_data_d   = lane_data_q;
    perm_start_d  = 1'b0;
    absorb_done_d = 1'b0;
    pop           = 1'b0;
    last_seen_d   = last_seen_q |
                    (bus.msgn_val && bus.lastmsgn_val && !fifo_full);
    ovf_err_d     = ovf_err_q | (bus.msgn_val && fifo_full);

    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d   = S_ABSORB;
          rate_d    = rate_of(bus.mode);
          lane_d    = '0;
          blk_cnt_d = '0;
          final_d   = 1'b0;
        end
      end

      S_ABSORB: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          lane_we_d   = 1'b1;
          lane_idx_d  = lane_q;
          lane_data_d = head[LANE_W-1:0];
          final_d     = head[LANE_W];
          if (lane_q == rate_q - 5'd1) begin
            // Block is full: the pad end byte shares the last lane if this
            // is also the last word.
            lane_d  = '0;
            state_d = S_PERM;
            if (head[LANE_W]) begin
              lane_data_d = head[LANE_W-1:0] ^ LANE_W'(PAD_END);
            end
          end else begin
            lane_d = lane_q + 5'd1;
            if (head[LANE_W]) begin
              state_d = S_PAD;
            end
          end
        end
      end

      S_PAD: begin
        // Intermediate zero lanes need no write; only the end byte does.
        lane_we_d   = 1'b1;
        lane_idx_d  = rate_q - 5'd1;
        lane_data_d = LANE_W'(PAD_END);
        state_d     = S_PERM;
      end

      S_PERM: begin
        // The start pulse trails the final lane write by one cycle so the
        // two never coincide.
        if (!perm_sent_q) begin
          perm_start_d = 1'b1;
          perm_sent_d  = 1'b1;
          blk_cnt_d    = blk_cnt_q + BLKCNT_W'(1);
        end else if (bus.perm_done) begin
          perm_sent_d = 1'b0;
          state_d     = final_q ? S_DONE : S_ABSORB;
        end
      end

      S_DONE: begin
        absorb_done_d = 1'b1;
        last_seen_d   = 1'b0;
        state_d       = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      rate_q        <= 5'(RATE128);
      lane_q        <= '0;
      blk_cnt_q     <= '0;
      last_seen_q   <= 1'b0;
      final_q       <= 1'b0;
      perm_sent_q   <= 1'b0;
      ovf_err_q     <= 1'b0;
      lane_we_q     <= 1'b0;
      lane_idx_q    <= '0;
      lane_data_q   <= '0;
      perm_start_q  <= 1'b0;
      absorb_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rate_q        <= rate_d;
      lane_q        <= lane_d;
      blk_cnt_q     <= blk_cnt_d;
      last_seen_q   <= last_seen_d;
      final_q       <= final_d;
      perm_sent_q   <= perm_sent_d;
      ovf_err_q     <= ovf_err_d;
      lane_we_q     <= lane_we_d;
      lane_idx_q    <= lane_idx_d;
      lane_data_q   <= lane_data_d;
      perm_start_q  <= perm_start_d;
      absorb_done_q <= absorb_done_d;
    end
  end

endmodule

// File: tb/tb_absorb_scheduler.sv
// -----------------------------------------------------------------------------
// tb_absorb_scheduler
// Directed bench for absorb_scheduler: full/short/two-block messages, a long
// stream with slow permutations, reset in PERM and FIFO overflow. A monitor
// records lane writes and pulses, and plays the Keccak core's perm_done.
// -----------------------------------------------------------------------------
module tb_absorb_scheduler;
  import keccak_pkg::*;

  typedef struct packed {
    logic [4:0]  idx;
    logic [63:0] data;
  } lane_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  absorb_scheduler_if #(.BLKCNT_W(16)) bus ();

  absorb_scheduler #(.FIFO_DEPTH(4), .BLKCNT_W(16)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  lane_t lanes[$];
  int    n_perm      = 0;
  int    n_done      = 0;
  int    excl_viol   = 0;
  bit    auto_done   = 1'b0;
  int    perm_delay  = 1;
  int    done_timer  = 0;
  int    done_req    = 0;
  int    done_served = 0;

  // Monitor and Keccak-core model; sole driver of perm_done.
  initial begin
    bus.perm_done = 1'b0;
    forever begin
      @(negedge clk);
      bus.perm_done = 1'b0;
      if (bus.lane_we) lanes.push_back(lane_t'({bus.lane_idx, bus.lane_data}));
      if (bus.perm_start) begin
        n_perm++;
        if (auto_done) done_timer = perm_delay;
      end
      if (bus.absorb_done) n_done++;
      if (int'(bus.lane_we) + int'(bus.perm_start) + int'(bus.absorb_done) > 1)
        excl_viol++;
      if (done_timer > 0) begin
        done_timer--;
        if (done_timer == 0) bus.perm_done = 1'b1;
      end else if (done_req != done_served) begin
        done_served++;
        bus.perm_done = 1'b1;
      end
    end
  end

  function automatic logic [63:0] mk_word(input int tag, input int i, input int n);
    logic [63:0] w;
    w = {8'(tag), 8'hC3, 16'(i * 37 + 5), 24'(i), 8'(i)};
    if (i == n - 1) w[7:0] = DOMAIN;
    return w;
  endfunction

  task automatic send_msg(input logic m, input int tag, input int n, output int stalls);
    int sent  = 0;
    int guard = 0;
    stalls   = 0;
    bus.mode = m;
    while (sent < n && guard < 5000) begin
      if (bus.in_ready) begin
        bus.msgn         = mk_word(tag, sent, n);
        bus.msgn_val     = 1'b1;
        bus.lastmsgn_val = (sent == n - 1);
        sent++;
      end else begin
        bus.msgn_val     = 1'b0;
        bus.lastmsgn_val = 1'b0;
        if (sent > 0) stalls++;
      end
      @(negedge clk);
      guard++;
    end
    bus.msgn_val     = 1'b0;
    bus.lastmsgn_val = 1'b0;
    n_checks++;
    if (sent !== n) begin
      n_fail++;
      $display("FAIL send_timeout tag %0d: sent %0d words, required %0d", tag, sent, n);
    end
  endtask

  // Sends one message with auto perm_done and checks every lane write against
  // an independent absorb model.
  task automatic run_msg(input string name, input logic m, input int tag,
                         input int n, input int delay, output int stalls);
    int    base_l = lanes.size();
    int    base_p = n_perm;
    int    base_d = n_done;
    int    rate   = m ? RATE256 : RATE128;
    int    guard  = 0;
    int    pos;
    int    nexp;
    lane_t exp_q[$];
    logic [63:0] d;
    auto_done  = 1'b1;
    perm_delay = delay;
    send_msg(m, tag, n, stalls);
    while (n_done == base_d && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (n_done - base_d !== 1) begin
      n_fail++;
      $display("FAIL %s absorb_done: got %0d pulses, required 1", name, n_done - base_d);
    end
    for (int w = 0; w < n; w++) begin
      pos = w % rate;
      d   = mk_word(tag, w, n);
      if (w == n - 1 && pos == rate - 1) d = d ^ 64'h80;
      exp_q.push_back(lane_t'({5'(pos), d}));
      if (w == n - 1 && pos != rate - 1)
        exp_q.push_back(lane_t'({5'(rate - 1), 64'h0000_0000_0000_0080}));
    end
    nexp = exp_q.size();
    n_checks++;
    if (lanes.size() - base_l !== nexp) begin
      n_fail++;
      $display("FAIL %s lane_count: got %0d, required %0d", name, lanes.size() - base_l, nexp);
    end
    for (int k = 0; k < nexp && base_l + k < lanes.size(); k++) begin
      n_checks++;
      if (lanes[base_l + k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL %s lane[%0d]: got idx %0d data %h, required idx %0d data %h",
                 name, k, lanes[base_l + k].idx, lanes[base_l + k].data,
                 exp_q[k].idx, exp_q[k].data);
      end
    end
    n_checks++;
    if (n_perm - base_p !== (n - 1) / rate + 1) begin
      n_fail++;
      $display("FAIL %s perm_start: got %0d, required %0d", name, n_perm - base_p, (n - 1) / rate + 1);
    end
    n_checks++;
    if (bus.blk_cnt !== 16'((n - 1) / rate + 1)) begin
      n_fail++;
      $display("FAIL %s blk_cnt: got %0d, required %0d", name, bus.blk_cnt, (n - 1) / rate + 1);
    end
    n_checks++;
    if (excl_viol !== 0 || bus.ovf_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s excl/ovf: got %0d overlaps ovf %b, required 0 and 0", name, excl_viol, bus.ovf_err);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.lane_we, bus.perm_start, bus.absorb_done, bus.busy, bus.ovf_err, bus.in_ready} !== 6'b000001) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, required 000001",
               {bus.lane_we, bus.perm_start, bus.absorb_done, bus.busy, bus.ovf_err, bus.in_ready});
    end
    n_checks++;
    if ({bus.blk_cnt, bus.lane_idx, bus.lane_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got blk %0d idx %0d data %h, required 0",
               bus.blk_cnt, bus.lane_idx, bus.lane_data);
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_block();
    int st;
    int last;
    run_msg("full_block", 1'b0, 8'h11, 21, 3, st);
    last = lanes.size() - 1;
    n_checks++;
    if (lanes[last].data[7:0] !== 8'h9F || lanes[last].idx !== 5'd20) begin
      n_fail++;
      $display("FAIL full_block_last: got idx %0d byte %h, required idx 20 byte 9f",
               lanes[last].idx, lanes[last].data[7:0]);
    end
  endtask

  task automatic test_short_pad();
    int st;
    run_msg("short_pad", 1'b1, 8'h22, 3, 2, st);
  endtask

  task automatic test_two_blocks();
    int st;
    run_msg("two_blocks", 1'b1, 8'h33, 18, 4, st);
  endtask

  task automatic test_back_to_back();
    int st;
    run_msg("stream50", 1'b0, 8'h44, 50, 30, st);
    n_checks++;
    if (!(st > 0)) begin
      n_fail++;
      $display("FAIL stream50 in_ready_drop: got %0d stall cycles, required > 0", st);
    end
  endtask

  task automatic test_reset_in_perm();
    int st;
    int base_p = n_perm;
    int base_l;
    int base_d;
    int guard  = 0;
    bit any_busy = 1'b0;
    auto_done = 1'b0;
    send_msg(1'b0, 8'h55, 3, st);
    while (n_perm == base_p && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (n_perm - base_p !== 1) begin
      n_fail++;
      $display("FAIL rst_perm_reach: got %0d perm_start, required 1", n_perm - base_p);
    end
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({bus.lane_we, bus.perm_start, bus.absorb_done, bus.busy, bus.ovf_err, bus.in_ready} !== 6'b000001) begin
      n_fail++;
      $display("FAIL rst_perm_flags: got %b, required 000001",
               {bus.lane_we, bus.perm_start, bus.absorb_done, bus.busy, bus.ovf_err, bus.in_ready});
    end
    n_checks++;
    if ({bus.blk_cnt, bus.lane_idx, bus.lane_data} !== '0) begin
      n_fail++;
      $display("FAIL rst_perm_values: got blk %0d idx %0d data %h, required 0",
               bus.blk_cnt, bus.lane_idx, bus.lane_data);
    end
    @(negedge clk);
    rstn   = 1'b1;
    base_l = lanes.size();
    base_p = n_perm;
    base_d = n_done;
    done_req++;
    repeat (10) begin
      @(negedge clk);
      if (bus.busy) any_busy = 1'b1;
    end
    n_checks++;
    if ({any_busy, lanes.size() != base_l, n_perm != base_p, n_done != base_d} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_perm_quiet: got busy %b writes %0d perms %0d dones %0d, required none",
               any_busy, lanes.size() - base_l, n_perm - base_p, n_done - base_d);
    end
  endtask

  task automatic test_overflow();
    int st;
    int base_p = n_perm;
    int guard  = 0;
    auto_done = 1'b0;
    send_msg(1'b1, 8'h66, 1, st);
    while (n_perm == base_p && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      bus.msgn         = mk_word(8'h77, i, 9);
      bus.msgn_val     = 1'b1;
      bus.lastmsgn_val = 1'b0;
      @(negedge clk);
      if (i == 3) begin
        n_checks++;
        if (bus.ovf_err !== 1'b0) begin
          n_fail++;
          $display("FAIL ovf_after4: got %b, required 0", bus.ovf_err);
        end
      end
    end
    bus.msgn_val = 1'b0;
    n_checks++;
    if (bus.ovf_err !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_after5: got %b, required 1", bus.ovf_err);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (bus.ovf_err !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: got %b, required 1", bus.ovf_err);
    end
    rstn = 1'b0;
    #1;
    n_checks++;
    if (bus.ovf_err !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_reset: got ovf %b in_ready %b, required 0 1", bus.ovf_err, bus.in_ready);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    bus.mode         = 1'b0;
    bus.msgn         = '0;
    bus.msgn_val     = 1'b0;
    bus.lastmsgn_val = 1'b0;
    test_reset();
    test_full_block();
    test_short_pad();
    test_two_blocks();
    test_back_to_back();
    test_reset_in_perm();
    test_overflow();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
